apresentador_sequencia: RTL and testbench
=========================================

Name: apresentador_sequencia

Overview:
- Plays the stored note sequence to the player on the 7 LEDs. It is the output side of the play-back game's LED/button interface: it shows the sequence, and the existing play-back datapath checks what the player presses against it.
- Reads addresses 0..limite from the synchronous sequence memory. Each note is lit for TEMPO_ON cycles, followed by a dark gap of TEMPO_OFF cycles. When the last note finishes it pulses fim.
- Sits beside the fluxo de dados. The unidade de controle starts it at the beginning of each round and waits for fim before entering the jogada phase.

Parameters:
- ADDR_W, 4, address/limite width (16-entry memory)
- NOTE_W, 7, note/LED width (one bit per button)
- TEMPO_ON, 2000, cycles each note is lit (must be >= 1)
- TEMPO_OFF, 500, cycles of dark gap after each note (must be >= 1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- iniciar  in  1  start request, sampled only in OCIOSO
- parar  in  1  abort; return to OCIOSO without fim
- limite  in  ADDR_W  index of the last note to show (0 = one note)
- dado_mem  in  NOTE_W  memory read data, valid 1 cycle after endereco
- endereco  out  ADDR_W  memory read address (registered)
- leds  out  NOTE_W  LED drive (registered)
- ocupado  out  1  high while a presentation is in progress
- fim  out  1  one-cycle pulse: sequence completed
- db_estado  out  3  current state code, for debug

Behaviour:
- Reset (reset=0 at an edge): state OCIOSO; endereco=0, leds=0, ocupado=0, fim=0, timer=0. Reset wins over every other input. A reset mid-presentation blanks the LEDs on the next edge.
- States and codes: OCIOSO=0, LE=1, ACENDE=2, APAGA=3, FIM=4.
- OCIOSO:
  - leds=0, ocupado=0.
  - iniciar=1 -> LE, endereco<=0, lim_reg<=limite.
  - limite is captured once here; later changes to limite are ignored until the next start.
- LE (exactly 1 cycle): memory latency slot. At the exit edge, leds<=dado_mem and the timer is cleared -> ACENDE.
- ACENDE:
  - leds hold the note for exactly TEMPO_ON cycles.
  - On the last cycle: leds<=0, timer cleared -> APAGA.
- APAGA:
  - leds=0 for exactly TEMPO_OFF cycles.
  - On the last cycle: if endereco==lim_reg -> FIM; else endereco<=endereco+1 -> LE.
- FIM (1 cycle): fim=1, ocupado=0 -> OCIOSO. endereco keeps its last value.
- ocupado=1 in LE, ACENDE and APAGA only.
- Cost per note: 1+TEMPO_ON+TEMPO_OFF cycles. Total from the iniciar-sampling edge to the fim-asserting edge: (lim_reg+1)*(1+TEMPO_ON+TEMPO_OFF) cycles.
- Timer width is $clog2(max(TEMPO_ON,TEMPO_OFF)+1). It compares against TEMPO-1 and never wraps.
- endereco never exceeds lim_reg. lim_reg=2^ADDR_W-1 shows all 16 entries with no wrap.
- dado_mem=0 is still timed as a normal (dark) note.
- iniciar while ocupado=1 or in FIM is ignored; it is not queued.
- parar=1 in any non-OCIOSO state:
  - Next edge: OCIOSO, leds=0, endereco=0, fim stays 0.
  - parar has priority over iniciar and over completion in the same cycle.
  - parar=1 in OCIOSO: stay idle; a simultaneous iniciar is ignored.
- All outputs are registered or decoded directly from the state register. No combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding constants (OCIOSO..FIM, 3-bit), plus NOTE_W/ADDR_W defaults, so the unidade de controle and the debug display decoders agree on them.
- One natural sub-module: contador_tempo. It is a cycle timer with parameter M, inputs zera and conta, and output fim_tempo high when count==M-1.
- Two instances, one for TEMPO_ON and one for TEMPO_OFF. Alternatively, one shared instance with a runtime limit mux.

Test Plan:
- Reset:
  - Setup: TEMPO_ON=4, TEMPO_OFF=2; hold reset=0 for 3 cycles while iniciar=1.
  - Expected: leds=0, endereco=0, ocupado=0, fim=0, db_estado=0 throughout.
- Full sequence:
  - Setup: limite=2, memory {0:7'h01, 1:7'h08, 2:7'h40}, TEMPO_ON=4, TEMPO_OFF=2; 1-cycle iniciar pulse.
  - Expected: leds show 01,08,40, each for exactly 4 cycles, separated by 2 dark cycles.
  - Expected: fim rises exactly 21 cycles after the sampling edge and is high for 1 cycle; ocupado falls on the same edge.
- Single note:
  - Setup: limite=0, mem[0]=7'h10.
  - Expected: 7'h10 lit for 4 cycles, fim 7 cycles after start, endereco stays 0.
- Abort mid-run:
  - Setup: limite=3; assert parar during note 1 ACENDE.
  - Expected: next edge leds=0, ocupado=0, endereco=0; fim is never asserted.
  - Expected: a following iniciar restarts from address 0.
- Ignored inputs:
  - Setup: re-pulse iniciar and change limite 3->0 mid-run.
  - Expected: the run continues to 4 notes (lim_reg=3) with unchanged timing; exactly one fim.
- Full-depth run:
  - Setup: limite=15.
  - Expected: addresses 0..15 each read once, no wrap, fim after 16*7=112 cycles.

Source files
------------

// File: rtl/apresentador_sequencia_pkg.sv
// Shared definitions for the sequence presenter and its neighbours.
// The state encoding is exported so the control unit and the debug
// display decoders interpret db_estado the same way.
package apresentador_sequencia_pkg;

  localparam int ADDR_W_PAD    = 4;
  localparam int NOTE_W_PAD    = 7;
  localparam int TEMPO_ON_PAD  = 2000;
  localparam int TEMPO_OFF_PAD = 500;
  localparam int ESTADO_W      = 3;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO = 3'd0,
    LE     = 3'd1,
    ACENDE = 3'd2,
    APAGA  = 3'd3,
    FIM    = 3'd4
  } estado_t;

endpackage

// File: rtl/apresentador_sequencia_if.sv
// Bus between the sequence presenter and the rest of the game.
//   iniciar   : start request
//   parar     : abort request
//   limite    : index of the last note to show
//   dado_mem  : sequence memory read data
//   endereco  : sequence memory read address
//   leds      : LED drive, one bit per button
//   ocupado   : presentation in progress
//   fim       : one-cycle pulse when the sequence has been shown
//   db_estado : current state code, for debug
// master: the side driving requests and memory data; slave: the presenter.
interface apresentador_sequencia_if
  import apresentador_sequencia_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_PAD,
  parameter int NOTE_W = NOTE_W_PAD
);

  logic                iniciar;
  logic                parar;
  logic [ADDR_W-1:0]   limite;
  logic [NOTE_W-1:0]   dado_mem;
  logic [ADDR_W-1:0]   endereco;
  logic [NOTE_W-1:0]   leds;
  logic                ocupado;
  logic                fim;
  logic [ESTADO_W-1:0] db_estado;

  modport master (
    output iniciar, parar, limite, dado_mem,
    input  endereco, leds, ocupado, fim, db_estado
  );

  modport slave (
    input  iniciar, parar, limite, dado_mem,
    output endereco, leds, ocupado, fim, db_estado
  );

endinterface

// File: rtl/apresentador_sequencia_contador_tempo.sv
// contador_tempo: cycle timer.
//   clock     : system clock, rising edge
//   reset     : synchronous, active-low
//   zera      : clear the count (wins over conta)
//   conta     : advance the count by one
//   fim_tempo : high while count == M-1
// The count saturates at M-1 instead of wrapping.
module contador_tempo #(
  parameter int M = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim_tempo
);

  localparam int             W      = $clog2(M + 1);
  localparam logic [W-1:0]   ULTIMO = W'(M - 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clock) begin
    if (!reset) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (conta && (contagem != ULTIMO)) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign fim_tempo = (contagem == ULTIMO);

endmodule

// File: rtl/apresentador_sequencia.sv
// apresentador_sequencia: plays the stored note sequence on the LEDs.
// Reads addresses 0..limite; each note is lit for TEMPO_ON cycles and
// followed by TEMPO_OFF dark cycles; fim pulses after the last note.
//   clock : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : slave side of apresentador_sequencia_if (requests, memory
//           port, LEDs and status)
module apresentador_sequencia
  import apresentador_sequencia_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_PAD,
  parameter int NOTE_W    = NOTE_W_PAD,
  parameter int TEMPO_ON  = TEMPO_ON_PAD,
  parameter int TEMPO_OFF = TEMPO_OFF_PAD
) (
  input  logic                    clock,
  input  logic                    reset,
  apresentador_sequencia_if.slave bus
);

  estado_t           estado;
  logic [ADDR_W-1:0] endereco;
  logic [ADDR_W-1:0] lim_reg;
  logic [NOTE_W-1:0] leds;
  logic              ocupado;
  logic              fim;

  logic fim_on;
  logic fim_off;

  // Each timer is held at zero outside its own state and is also cleared on
  // its last cycle, so it is already zero when its state is next entered.
  contador_tempo #(.M(TEMPO_ON)) u_tempo_on (
    .clock     (clock),
    .reset     (reset),
    .zera      ((estado != ACENDE) || fim_on),
    .conta     (estado == ACENDE),
    .fim_tempo (fim_on)
  );

  contador_tempo #(.M(TEMPO_OFF)) u_tempo_off (
    .clock     (clock),
    .reset     (reset),
    .zera      ((estado != APAGA) || fim_off),
    .conta     (estado == APAGA),
    .fim_tempo (fim_off)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= OCIOSO;
      endereco <= '0;
      lim_reg  <= '0;
      leds     <= '0;
      ocupado  <= 1'b0;
      fim      <= 1'b0;
    end else if (bus.parar && (estado != OCIOSO)) begin
      // Abort beats start and completion alike; no fim is produced.
      estado   <= OCIOSO;
      endereco <= '0;
      leds     <= '0;
      ocupado  <= 1'b0;
      fim      <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          leds    <= '0;
          ocupado <= 1'b0;
          fim     <= 1'b0;
          if (bus.iniciar && !bus.parar) begin
            estado   <= LE;
            endereco <= '0;
            lim_reg  <= bus.limite;
            ocupado  <= 1'b1;
          end
        end
        LE: begin
          leds   <= bus.dado_mem;
          estado <= ACENDE;
        end
        ACENDE: begin
          if (fim_on) begin
            leds   <= '0;
            estado <= APAGA;
          end
        end
        APAGA: begin
          if (fim_off) begin
            if (endereco == lim_reg) begin
              estado  <= FIM;
              fim     <= 1'b1;
              ocupado <= 1'b0;
            end else begin
              endereco <= endereco + 1'b1;
              estado   <= LE;
            end
          end
        end
        FIM: begin
          fim    <= 1'b0;
          estado <= OCIOSO;
        end
        default: begin
          estado  <= OCIOSO;
          leds    <= '0;
          ocupado <= 1'b0;
          fim     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.endereco  = endereco;
  assign bus.leds      = leds;
  assign bus.ocupado   = ocupado;
  assign bus.fim       = fim;
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_apresentador_sequencia.sv
// Self-checking bench for apresentador_sequencia with TEMPO_ON=4,
// TEMPO_OFF=2. Expected per-cycle outputs are derived from the note
// timeline and queued when a run is started, then popped as cycles pass.
module tb_apresentador_sequencia;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int PER   = 1 + T_ON + T_OFF;

  typedef struct packed {
    logic [6:0] leds;
    logic [3:0] endereco;
    logic       ocupado;
    logic       fim;
    logic [2:0] estado;
  } saida_t;

  typedef struct {
    logic [3:0] limite;
    logic [6:0] n0;
    logic [6:0] n1;
    logic [6:0] n2;
    bit         perturba;
    int         fim_c;
  } caso_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] mem [16];

  int n_vec = 0;
  int n_err = 0;

  saida_t q[$];

  apresentador_sequencia_if #(.ADDR_W(4), .NOTE_W(7)) bus ();

  apresentador_sequencia #(
    .ADDR_W    (4),
    .NOTE_W    (7),
    .TEMPO_ON  (T_ON),
    .TEMPO_OFF (T_OFF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign bus.dado_mem = mem[bus.endereco];

  function automatic saida_t ocioso(input logic [3:0] e);
    saida_t s;
    s = '0;
    s.endereco = e;
    return s;
  endfunction

  // Output expected c edges after the edge that sampled iniciar, for a
  // run of nl notes.
  function automatic saida_t esperado(input int c, input int nl);
    saida_t s;
    int k;
    int f;
    s = '0;
    k = c / PER;
    f = c % PER;
    if (c >= nl * PER) begin
      s.endereco = 4'(nl - 1);
      s.fim      = (c == nl * PER);
      s.estado   = (c == nl * PER) ? 3'd4 : 3'd0;
    end else begin
      s.endereco = 4'(k);
      s.ocupado  = 1'b1;
      if (f == 0) begin
        s.estado = 3'd1;
      end else if (f <= T_ON) begin
        s.estado = 3'd2;
        s.leds   = mem[k];
      end else begin
        s.estado = 3'd3;
      end
    end
    return s;
  endfunction

  task automatic passo();
    @(posedge clock);
    #1;
  endtask

  task automatic confere(input string nome);
    saida_t exp;
    saida_t act;
    act.leds     = bus.leds;
    act.endereco = bus.endereco;
    act.ocupado  = bus.ocupado;
    act.fim      = bus.fim;
    act.estado   = bus.db_estado;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h", nome, act);
    end else begin
      exp = q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s: got leds=%h end=%0d ocup=%b fim=%b est=%0d, want leds=%h end=%0d ocup=%b fim=%b est=%0d",
                 nome, act.leds, act.endereco, act.ocupado, act.fim, act.estado,
                 exp.leds, exp.endereco, exp.ocupado, exp.fim, exp.estado);
      end
    end
  endtask

  task automatic cheque_int(input string nome, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nome, got, want);
    end
  endtask

  // Starts a run of limite L and checks every cycle up to one idle cycle
  // after FIM, plus the cycle at which fim appears and how often.
  task automatic executa(input logic [3:0] L, input bit perturba, input int exp_fim);
    int nl;
    int ultimo;
    int fim_c;
    int nfim;
    nl     = int'(L) + 1;
    ultimo = nl * PER + 1;
    fim_c  = -1;
    nfim   = 0;
    bus.limite  = L;
    bus.iniciar = 1'b1;
    for (int c = 0; c <= ultimo; c++) q.push_back(esperado(c, nl));
    for (int c = 0; c <= ultimo; c++) begin
      passo();
      if (c == 0) bus.iniciar = 1'b0;
      if (bus.fim === 1'b1) begin
        nfim++;
        if (fim_c < 0) fim_c = c;
      end
      confere("sequencia");
      if (perturba) begin
        if (c == 10) begin
          bus.iniciar = 1'b1;
          bus.limite  = 4'd0;
        end
        if (c == 11) bus.iniciar = 1'b0;
        if (c == nl * PER - 1) bus.iniciar = 1'b1;
        if (c == nl * PER) bus.iniciar = 1'b0;
      end
    end
    cheque_int("fim_ciclo", fim_c, exp_fim);
    cheque_int("fim_contagem", nfim, 1);
  endtask

  caso_t tabela[4];

  initial begin
    tabela[0] = '{4'd2,  7'h01, 7'h08, 7'h40, 1'b0, 21};
    tabela[1] = '{4'd0,  7'h10, 7'h08, 7'h40, 1'b0, 7};
    tabela[2] = '{4'd15, 7'h22, 7'h05, 7'h7f, 1'b0, 112};
    tabela[3] = '{4'd3,  7'h03, 7'h0c, 7'h30, 1'b1, 28};

    for (int i = 0; i < 16; i++) mem[i] = 7'((i * 37 + 11) % 128);
    mem[5] = 7'h00;

    // Reset held with iniciar high: stays idle and dark.
    reset       = 1'b0;
    bus.iniciar = 1'b1;
    bus.parar   = 1'b0;
    bus.limite  = 4'd3;
    for (int i = 0; i < 3; i++) begin
      q.push_back(ocioso(4'd0));
      passo();
      confere("reset");
    end
    reset       = 1'b1;
    bus.iniciar = 1'b0;
    q.push_back(ocioso(4'd0));
    passo();
    confere("pos_reset");

    foreach (tabela[i]) begin
      mem[0] = tabela[i].n0;
      mem[1] = tabela[i].n1;
      mem[2] = tabela[i].n2;
      executa(tabela[i].limite, tabela[i].perturba, tabela[i].fim_c);
    end

    // Abort during note 1 lit phase.
    bus.limite  = 4'd3;
    bus.iniciar = 1'b1;
    for (int c = 0; c <= 8; c++) q.push_back(esperado(c, 4));
    for (int c = 0; c <= 8; c++) begin
      passo();
      if (c == 0) bus.iniciar = 1'b0;
      confere("aborto_pre");
    end
    bus.parar = 1'b1;
    q.push_back(ocioso(4'd0));
    passo();
    confere("aborto");
    bus.parar = 1'b0;
    for (int i = 0; i < 10; i++) begin
      q.push_back(ocioso(4'd0));
      passo();
      confere("aborto_ocioso");
    end
    executa(4'd1, 1'b0, 14);

    // Abort on the last dark cycle beats completion.
    bus.limite  = 4'd0;
    bus.iniciar = 1'b1;
    for (int c = 0; c <= 6; c++) q.push_back(esperado(c, 1));
    for (int c = 0; c <= 6; c++) begin
      passo();
      if (c == 0) bus.iniciar = 1'b0;
      confere("parar_fim_pre");
    end
    bus.parar = 1'b1;
    q.push_back(ocioso(4'd0));
    passo();
    confere("parar_vs_fim");

    // parar with iniciar while idle: no start.
    bus.iniciar = 1'b1;
    q.push_back(ocioso(4'd0));
    passo();
    confere("parar_ocioso");
    bus.parar   = 1'b0;
    bus.iniciar = 1'b0;
    q.push_back(ocioso(4'd0));
    passo();
    confere("parar_ocioso2");

    // Reset mid-presentation blanks the LEDs on the next edge.
    bus.limite  = 4'd2;
    bus.iniciar = 1'b1;
    for (int c = 0; c <= 2; c++) q.push_back(esperado(c, 3));
    for (int c = 0; c <= 2; c++) begin
      passo();
      if (c == 0) bus.iniciar = 1'b0;
      confere("reset_meio_pre");
    end
    reset = 1'b0;
    q.push_back(ocioso(4'd0));
    passo();
    confere("reset_meio");
    reset = 1'b1;
    q.push_back(ocioso(4'd0));
    passo();
    confere("reset_meio_pos");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
